multicycle_control: RTL

- Parametrised multicycle main control unit for the 64-bit core.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB instead of a single decode per clock.
- Drives the existing datapath control bundle: ALUOp, ALUsrc, memRead, memWrite, regWrite, memToReg, branch.
- Adds an instruction handshake, memory wait states, illegal-opcode trap and a retired-instruction counter.

---
 rtl/multicycle_control.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control.sv
// multicycle_control
// Multicycle main control unit for the 64-bit core. Each instruction walks
// FETCH -> DECODE -> EXEC -> (MEM) -> (WB) -> FETCH. The unit drives the
// datapath control bundle from the state register and the opcode class
// latched in FETCH.
//
// Handshake: instr_ack is high in every FETCH cycle. An instruction
// transfers on a rising edge where instr_valid and instr_ack are both high.
// The producer must hold instr stable while instr_valid is high. In MEM,
// the access completes on the first edge where mem_ready is sampled high.
// mem_ready is ignored in every other state.
//
// Optional build macro MEM_TIMEOUT_EN: bounds MEM waits to TIMEOUT cycles.
// When the bound is hit, the unit pulses mem_err for one cycle and abandons
// the instruction without retiring it.
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   instr_valid, instr    opcode offer from fetch
//   instr_ack             control accepts an instruction (FETCH)
//   zero                  ALU zero flag for branches
//   mem_ready             data memory completes current access
//   ALUOp, ALUsrc, memRead, memWrite, regWrite, memToReg, branch
//                         datapath control bundle (Moore)
//   pc_taken              branch & zero, combinational in EXEC
//   illegal               one-cycle pulse in TRAP
//   state                 current state code (debug)
//   retire_cnt            retired-instruction counter (wraps)
//   mem_err               MEM timeout pulse (0 without MEM_TIMEOUT_EN)
module multicycle_control #(
  parameter int OPC_W   = 7,
  parameter int ALUOP_W = 2,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               instr_valid,
  input  logic [OPC_W-1:0]   instr,
  output logic               instr_ack,
  input  logic               zero,
  input  logic               mem_ready,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               ALUsrc,
  output logic               memRead,
  output logic               memWrite,
  output logic               regWrite,
  output logic               memToReg,
  output logic               branch,
  output logic               pc_taken,
  output logic               illegal,
  output logic [2:0]         state,
  output logic [CNT_W-1:0]   retire_cnt,
  output logic               mem_err
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    C_NONE    = 3'd0,
    C_R       = 3'd1,
    C_IALU    = 3'd2,
    C_LOAD    = 3'd3,
    C_STORE   = 3'd4,
    C_BRANCH  = 3'd5,
    C_ILLEGAL = 3'd6
  } class_t;

  state_t           state_q, state_d;
  class_t           class_q, class_d;
  class_t           instr_class;
  logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;
  logic             retire;
  logic             mem_done;
  logic             mem_abort;
  logic [1:0]       alu_op;

  // Matching the full-width opcode forces any bits above [6:0] to be zero.
  always_comb begin
    instr_class = C_ILLEGAL;
    case (instr)
      OPC_W'(7'h33): instr_class = C_R;
      OPC_W'(7'h13): instr_class = C_IALU;
      OPC_W'(7'h03): instr_class = C_LOAD;
      OPC_W'(7'h23): instr_class = C_STORE;
      OPC_W'(7'h63): instr_class = C_BRANCH;
      default:       instr_class = C_ILLEGAL;
    endcase
  end

  assign mem_done = (state_q == S_MEM) && mem_ready;

`ifdef MEM_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              mem_err_q, mem_err_d;

  // The count holds the wait cycles seen so far in this MEM visit. The abort
  // fires on the wait cycle that brings the count to TIMEOUT. A ready in
  // that same cycle still wins, because mem_done is checked first.
  assign mem_abort = (state_q == S_MEM) && !mem_ready &&
                     (wait_cnt_q == WAIT_W'(TIMEOUT - 1));

  always_comb begin
    wait_cnt_d = '0;
    if (state_q == S_MEM && !mem_ready) wait_cnt_d = wait_cnt_q + 1'b1;
    mem_err_d = mem_abort;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
    end
  end

  assign mem_err = mem_err_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
  assign mem_abort      = 1'b0;
  assign mem_err        = 1'b0;
`endif

  // Next state, class latch and retire strobe.
  always_comb begin
    state_d = S_FETCH;
    class_d = class_q;
    retire  = 1'b0;
    case (state_q)
      S_FETCH: begin
        state_d = S_FETCH;
        if (instr_valid) begin
          class_d = instr_class;
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = (class_q == C_ILLEGAL) ? S_TRAP : S_EXEC;
      S_EXEC: begin
        case (class_q)
          C_LOAD, C_STORE: state_d = S_MEM;
          C_BRANCH: begin
            state_d = S_FETCH;
            retire  = 1'b1;
          end
          default: state_d = S_WB;
        endcase
      end
      S_MEM: begin
        state_d = S_MEM;
        if (mem_done) begin
          if (class_q == C_LOAD) begin
            state_d = S_WB;
          end else begin
            state_d = S_FETCH;
            retire  = 1'b1;
          end
        end else if (mem_abort) begin
          state_d = S_FETCH;
        end
      end
      S_WB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_TRAP:  state_d = S_FETCH;
      default: state_d = S_FETCH;  // codes 6/7 recover
    endcase
    retire_cnt_d = retire ? retire_cnt_q + 1'b1 : retire_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_FETCH;
      class_q      <= C_NONE;
      retire_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      class_q      <= class_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  // Moore outputs. pc_taken is the only term that looks at a live input.
  always_comb begin
    instr_ack = 1'b0;
    alu_op    = 2'b00;
    ALUsrc    = 1'b0;
    memRead   = 1'b0;
    memWrite  = 1'b0;
    regWrite  = 1'b0;
    memToReg  = 1'b0;
    branch    = 1'b0;
    illegal   = 1'b0;
    case (state_q)
      S_FETCH: instr_ack = 1'b1;
      S_EXEC: begin
        case (class_q)
          C_R:    alu_op = 2'b10;
          C_IALU: begin
            alu_op = 2'b10;
            ALUsrc = 1'b1;
          end
          C_LOAD, C_STORE: begin
            alu_op = 2'b00;
            ALUsrc = 1'b1;
          end
          C_BRANCH: begin
            alu_op = 2'b01;
            branch = 1'b1;
          end
          default: alu_op = 2'b00;
        endcase
      end
      S_MEM: begin
        memRead  = (class_q == C_LOAD);
        memWrite = (class_q == C_STORE);
      end
      S_WB: begin
        regWrite = 1'b1;
        memToReg = (class_q == C_LOAD);
      end
      S_TRAP:  illegal = 1'b1;
      default: ;
    endcase
  end

  assign ALUOp      = ALUOP_W'(alu_op);
  assign pc_taken   = branch & zero;
  assign state      = state_q;
  assign retire_cnt = retire_cnt_q;

endmodule
